// File: rtl/lcd_pkg.sv
// Shared types, timing defaults and encodings for the HD44780 read-side logic.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE
  } rd_state_e;

  localparam int unsigned DEF_SETUP_CYCLES   = 3;
  localparam int unsigned DEF_EN_HIGH_CYCLES = 12;
  localparam int unsigned DEF_HOLD_CYCLES    = 2;
  localparam int unsigned DEF_POLL_CYCLES    = 50;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BF_BIT = 7;

  localparam logic RS_INSTR = 1'b0;
  localparam logic RS_DATA  = 1'b1;

  // Byte returned by an RS=0 read: busy flag on top of the address counter.
  typedef struct packed {
    logic              busy;
    logic [BF_BIT-1:0] addr;
  } lcd_status_t;

  // Bits needed to hold the values 0..n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_phase_counter.sv
// Loadable down-counter that holds at zero and flags terminal count.
// Used both for bus phase timing and for the busy-flag poll interval.
module lcd_phase_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= WIDTH'(RESET_VAL);
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/lcd_status_reader.sv
// HD44780 read engine: polls the busy flag / address counter or reads a data-RAM
// byte while it owns the shared LCD control lines (bus_active).
module lcd_status_reader
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int unsigned EN_HIGH_CYCLES = DEF_EN_HIGH_CYCLES,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned POLL_CYCLES    = DEF_POLL_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bus_gnt,
  input  logic              poll_en,
  input  logic              rd_req,
  input  logic              rd_rs,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy_flag,
  output logic [BF_BIT-1:0] addr_counter,
  output logic              lcd_busy,
  output logic              bus_active,
  output logic              lcd_rw,
  output logic              lcd_en,
  output logic              lcd_rs,
  input  logic [DATA_W-1:0] lcd_data_in
);

  localparam int unsigned PHASE_MAX =
    (SETUP_CYCLES > EN_HIGH_CYCLES)
      ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
      : ((EN_HIGH_CYCLES > HOLD_CYCLES) ? EN_HIGH_CYCLES : HOLD_CYCLES);
  localparam int unsigned PHASE_W = cnt_width(PHASE_MAX);
  localparam int unsigned POLL_W  = cnt_width(POLL_CYCLES);

  localparam logic [PHASE_W-1:0] SETUP_LOAD = PHASE_W'(SETUP_CYCLES - 1);
  localparam logic [PHASE_W-1:0] EN_LOAD    = PHASE_W'(EN_HIGH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HOLD_LOAD  = PHASE_W'(HOLD_CYCLES - 1);
  localparam logic [POLL_W-1:0]  POLL_LOAD  = POLL_W'(POLL_CYCLES - 1);

  rd_state_e         state_q;
  logic              rs_q;
  logic [DATA_W-1:0] cap_q;
  logic [DATA_W-1:0] rd_data_q;
  lcd_status_t       status_q;
  logic              lcd_busy_q;
  logic              rd_valid_q;
  logic              bus_active_q;
  logic              lcd_rw_q;
  logic              lcd_en_q;
  logic              lcd_rs_q;

  logic               start;
  logic               start_rs;
  logic               phase_load;
  logic [PHASE_W-1:0] phase_val;
  logic               phase_tc;
  logic               poll_tc;

  // An explicit request beats a poll expiring in the same cycle.
  always_comb begin
    start    = 1'b0;
    start_rs = RS_INSTR;
    if ((state_q == ST_IDLE) && bus_gnt) begin
      if (rd_req) begin
        start    = 1'b1;
        start_rs = rd_rs;
      end else if (poll_en && poll_tc) begin
        start = 1'b1;
      end
    end
  end

  // Phase counter is reloaded on every entry to a timed state.
  always_comb begin
    phase_load = 1'b0;
    phase_val  = SETUP_LOAD;
    unique case (state_q)
      ST_IDLE: phase_load = start;
      ST_SETUP: begin
        if (phase_tc) begin
          phase_load = 1'b1;
          phase_val  = EN_LOAD;
        end
      end
      ST_STROBE: begin
        if (phase_tc) begin
          phase_load = 1'b1;
          phase_val  = HOLD_LOAD;
        end
      end
      default: phase_load = 1'b0;
    endcase
  end

  lcd_phase_counter #(
    .WIDTH     (PHASE_W),
    .RESET_VAL (0)
  ) u_phase (
    .clock      (clock),
    .reset      (reset),
    .load_i     (phase_load),
    .load_val_i (phase_val),
    .dec_i      (state_q != ST_IDLE),
    .tc_o       (phase_tc)
  );

  // Poll interval restarts whenever the block returns to IDLE.
  lcd_phase_counter #(
    .WIDTH     (POLL_W),
    .RESET_VAL (POLL_CYCLES - 1)
  ) u_poll (
    .clock      (clock),
    .reset      (reset),
    .load_i     (state_q == ST_DONE),
    .load_val_i (POLL_LOAD),
    .dec_i      ((state_q == ST_IDLE) && poll_en && bus_gnt),
    .tc_o       (poll_tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rs_q         <= RS_INSTR;
      cap_q        <= '0;
      rd_data_q    <= '0;
      status_q     <= '{busy: 1'b1, addr: '0};
      lcd_busy_q   <= 1'b1;
      rd_valid_q   <= 1'b0;
      bus_active_q <= 1'b0;
      lcd_rw_q     <= 1'b0;
      lcd_en_q     <= 1'b0;
      lcd_rs_q     <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q      <= ST_SETUP;
            rs_q         <= start_rs;
            bus_active_q <= 1'b1;
            lcd_rw_q     <= 1'b1;
            lcd_rs_q     <= start_rs;
          end
        end
        ST_SETUP: begin
          if (phase_tc) begin
            state_q  <= ST_STROBE;
            lcd_en_q <= 1'b1;
          end
        end
        ST_STROBE: begin
          // Last EN-high cycle: data is valid on the bus now.
          if (phase_tc) begin
            state_q  <= ST_HOLD;
            lcd_en_q <= 1'b0;
            cap_q    <= lcd_data_in;
          end
        end
        ST_HOLD: begin
          if (phase_tc) begin
            state_q      <= ST_DONE;
            bus_active_q <= 1'b0;
            lcd_rw_q     <= 1'b0;
            lcd_rs_q     <= 1'b0;
            rd_valid_q   <= 1'b1;
            rd_data_q    <= cap_q;
            if (rs_q != RS_DATA) begin
              status_q   <= lcd_status_t'(cap_q);
              lcd_busy_q <= cap_q[BF_BIT];
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_ready     = (state_q == ST_IDLE) && bus_gnt && !reset;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign busy_flag    = status_q.busy;
  assign addr_counter = status_q.addr;
  assign lcd_busy     = lcd_busy_q;
  assign bus_active   = bus_active_q;
  assign lcd_rw       = lcd_rw_q;
  assign lcd_en       = lcd_en_q;
  assign lcd_rs       = lcd_rs_q;

endmodule

// File: tb/tb_lcd_status_reader.sv
// Bench for lcd_status_reader: timeline-based reference model checked every cycle,
// directed scenarios with hand-computed expectations, then randomized traffic.
module tb_lcd_status_reader;
  import lcd_pkg::*;

  localparam int S    = 3;
  localparam int E    = 12;
  localparam int H    = 2;
  localparam int P    = 50;
  localparam int LAST = S + E + H;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       bus_gnt = 1'b1;
  logic       poll_en = 1'b0;
  logic       rd_req = 1'b0;
  logic       rd_rs = 1'b0;
  logic [7:0] lcd_data_in = 8'h00;
  logic       rd_ready, rd_valid, busy_flag, lcd_busy, bus_active, lcd_rw, lcd_en, lcd_rs;
  logic [7:0] rd_data;
  logic [6:0] addr_counter;

  int         errors = 0;
  int         checks = 0;
  logic       rand_mode = 1'b0;
  logic [7:0] lcd_val = 8'h00;

  lcd_status_reader #(
    .SETUP_CYCLES   (S),
    .EN_HIGH_CYCLES (E),
    .HOLD_CYCLES    (H),
    .POLL_CYCLES    (P)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus_gnt      (bus_gnt),
    .poll_en      (poll_en),
    .rd_req       (rd_req),
    .rd_rs        (rd_rs),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .busy_flag    (busy_flag),
    .addr_counter (addr_counter),
    .lcd_busy     (lcd_busy),
    .bus_active   (bus_active),
    .lcd_rw       (lcd_rw),
    .lcd_en       (lcd_en),
    .lcd_rs       (lcd_rs),
    .lcd_data_in  (lcd_data_in)
  );

  always #5 clock = ~clock;

  // LCD side: fixed byte in directed tests, fresh noise every cycle when random.
  always @(negedge clock) lcd_data_in = rand_mode ? 8'($urandom) : lcd_val;

  // Reference model: ofs counts edges since a read was accepted (-1 = idle).
  int         ofs = -1;
  int         poll = P - 1;
  logic       m_rs = 1'b0;
  logic       m_busy = 1'b1;
  logic       m_bf = 1'b1;
  logic [6:0] m_ac = 7'h00;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_cap = 8'h00;
  logic       exp_bus;
  logic [22:0] exp_v, got_v;

  always @(posedge clock) begin
    if (reset) begin
      ofs = -1; poll = P - 1;
      m_busy = 1'b1; m_bf = 1'b1; m_ac = 7'h00; m_data = 8'h00;
    end else if (ofs < 0) begin
      if (rd_req && bus_gnt) begin
        ofs = 0; m_rs = rd_rs;
      end else if (poll_en && bus_gnt && poll == 0) begin
        ofs = 0; m_rs = RS_INSTR;
      end else if (poll_en && bus_gnt) begin
        poll--;
      end
    end else begin
      ofs++;
      if (ofs == S + E) m_cap = lcd_data_in;
      if (ofs == LAST) begin
        m_data = m_cap;
        if (m_rs == RS_INSTR) begin
          m_busy = m_cap[7]; m_bf = m_cap[7]; m_ac = m_cap[6:0];
        end
      end
      if (ofs > LAST) begin
        ofs = -1; poll = P - 1;
      end
    end
    #1;
    exp_bus = (ofs >= 0) && (ofs < LAST);
    exp_v = {(ofs < 0) && bus_gnt && !reset, ofs == LAST, exp_bus, exp_bus,
             (ofs >= S) && (ofs < S + E), exp_bus & m_rs, m_busy, m_bf, m_ac, m_data};
    got_v = {rd_ready, rd_valid, bus_active, lcd_rw, lcd_en, lcd_rs,
             lcd_busy, busy_flag, addr_counter, rd_data};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_compare t=%0t got=%06h exp=%06h", $time, got_v, exp_v);
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Wait (bounded) for rd_valid; request is a one-cycle pulse.
  task automatic wait_valid(output int n, output int en_cnt, output int rs_cnt);
    n = 0; en_cnt = 0; rs_cnt = 0;
    do begin
      tick();
      rd_req = 1'b0;
      n++;
      if (lcd_en) en_cnt++;
      if (bus_active && lcd_rs) rs_cnt++;
    end while (!rd_valid && n < 300);
    if (!rd_valid) chk("wait_valid_timeout", 32'(n), 32'(0));
  endtask

  int n, en_c, rs_c, cnt;

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rd_ready_in_reset", 32'(rd_ready), 32'(0));
    chk("reset_lcd_busy", 32'(lcd_busy), 32'(1));
    chk("reset_busy_flag", 32'(busy_flag), 32'(1));
    chk("reset_rd_data", 32'(rd_data), 32'(0));

    // 1: first poll after 50 idle clocks returns 0x85
    reset = 1'b0; poll_en = 1'b1; lcd_val = 8'h85;
    wait_valid(n, en_c, rs_c);
    chk("t1_latency", 32'(n), 32'(67));
    chk("t1_en_width", 32'(en_c), 32'(12));
    chk("t1_rd_data", 32'(rd_data), 32'h85);
    chk("t1_busy_flag", 32'(busy_flag), 32'(1));
    chk("t1_addr", 32'(addr_counter), 32'h05);
    chk("t1_lcd_busy", 32'(lcd_busy), 32'(1));

    // 2: next poll returns 0x27
    lcd_val = 8'h27;
    wait_valid(n, en_c, rs_c);
    chk("t2_interval", 32'(n), 32'(68));
    chk("t2_lcd_busy", 32'(lcd_busy), 32'(0));
    chk("t2_addr", 32'(addr_counter), 32'h27);

    // 3: explicit data-RAM read
    poll_en = 1'b0;
    tick();
    chk("t3_rd_ready", 32'(rd_ready), 32'(1));
    rd_req = 1'b1; rd_rs = RS_DATA; lcd_val = 8'h41;
    wait_valid(n, en_c, rs_c);
    chk("t3_latency", 32'(n), 32'(18));
    chk("t3_rs_cycles", 32'(rs_c), 32'(17));
    chk("t3_rd_data", 32'(rd_data), 32'h41);
    chk("t3_lcd_busy", 32'(lcd_busy), 32'(0));
    chk("t3_addr", 32'(addr_counter), 32'h27);

    // 4: request collides with poll expiry
    poll_en = 1'b1;
    repeat (50) tick();
    rd_req = 1'b1; rd_rs = RS_DATA; lcd_val = 8'h5A;
    wait_valid(n, en_c, rs_c);
    chk("t4_latency", 32'(n), 32'(18));
    chk("t4_rs_cycles", 32'(rs_c), 32'(17));
    chk("t4_rd_data", 32'(rd_data), 32'h5A);
    lcd_val = 8'h00;
    wait_valid(n, en_c, rs_c);
    chk("t4_next_poll", 32'(n), 32'(68));
    chk("t4_addr", 32'(addr_counter), 32'h00);

    // 5: grant withheld at expiry, then dropped mid-read
    repeat (50) tick();
    bus_gnt = 1'b0;
    cnt = 0;
    repeat (30) begin
      tick();
      if (bus_active || rd_ready) cnt++;
    end
    chk("t5_no_start", 32'(cnt), 32'(0));
    bus_gnt = 1'b1; lcd_val = 8'h13;
    tick();
    chk("t5_start_on_gnt", 32'(bus_active), 32'(1));
    repeat (5) tick();
    bus_gnt = 1'b0;
    wait_valid(n, en_c, rs_c);
    chk("t5_latency", 32'(n), 32'(12));
    chk("t5_addr", 32'(addr_counter), 32'h13);
    chk("t5_lcd_busy", 32'(lcd_busy), 32'(0));
    bus_gnt = 1'b1;

    // 6: reset during strobe
    poll_en = 1'b0;
    tick();
    rd_req = 1'b1; rd_rs = RS_INSTR; lcd_val = 8'h00;
    tick();
    rd_req = 1'b0;
    repeat (6) tick();
    chk("t6_in_strobe", 32'(lcd_en), 32'(1));
    reset = 1'b1;
    tick();
    chk("t6_en_drop", 32'(lcd_en), 32'(0));
    chk("t6_rw_drop", 32'(lcd_rw), 32'(0));
    tick();
    reset = 1'b0;
    cnt = 0;
    repeat (30) begin
      tick();
      if (rd_valid) cnt++;
    end
    chk("t6_no_valid", 32'(cnt), 32'(0));
    chk("t6_lcd_busy", 32'(lcd_busy), 32'(1));

    // Randomized traffic
    rand_mode = 1'b1;
    repeat (3000) begin
      tick();
      bus_gnt = ($urandom_range(9) != 0);
      poll_en = 1'($urandom_range(1));
      rd_req  = ($urandom_range(3) == 0);
      rd_rs   = 1'($urandom_range(1));
      reset   = ($urandom_range(499) == 0);
    end
    reset = 1'b0; rd_req = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_status_reader.md
# lcd_status_reader

Read-side companion to the LCD write bridge: runs HD44780 read cycles (RW=1) to fetch the busy flag and address counter, or a data-RAM byte, from the character LCD module. It feeds a real `lcd_busy` to the key-logic FSM and lets the write bridge hold off while the controller is still executing. It shares the LCD bus with the write bridge and owns the RW/EN/RS lines only while it holds `bus_active`.

## Interface
- `SETUP_CYCLES`, default 3: clocks with RW/RS valid and EN low before the strobe (tAS ≥ 40 ns at 50 MHz).
- `EN_HIGH_CYCLES`, default 12: EN high width in clocks (≥ 230 ns). Data is sampled on the last cycle.
- `HOLD_CYCLES`, default 2: clocks with EN low and RW still high after the strobe (tH).
- `POLL_CYCLES`, default 50: idle clocks between automatic busy-flag polls.
- `clock` in, 1 bit: system clock. All logic is rising-edge.
- `reset` in, 1 bit: synchronous reset, active-high.
- `bus_gnt` in, 1 bit: the write bridge is idle and yields the bus. It is checked only when a read starts.
- `poll_en` in, 1 bit: enables automatic busy-flag reads.
- `rd_req` in, 1 bit: request an explicit read. Accepted when `rd_req & rd_ready`.
- `rd_rs` in, 1 bit: RS for the explicit read (0 = busy flag/address, 1 = data RAM). Sampled at accept.
- `rd_ready` out, 1 bit: block is IDLE and `bus_gnt` is high.
- `rd_valid` out, 1 bit: one-cycle pulse when `rd_data` is updated.
- `rd_data` out, 8 bits: last byte read.
- `busy_flag` out, 1 bit: bit 7 of the last RS=0 read.
- `addr_counter` out, 7 bits: bits 6:0 of the last RS=0 read.
- `lcd_busy` out, 1 bit: conservative busy indication for the FSM.
- `bus_active` out, 1 bit: high from SETUP through HOLD. The top-level mux uses it to select this block's RW/EN/RS and to tri-state `lcd_data`.
- `lcd_rw`, `lcd_en`, `lcd_rs` out, 1 bit each: LCD control lines, valid while `bus_active` is high.
- `lcd_data_in` in, 8 bits: LCD data bus as seen through the top-level tri-state buffer.

## Operation
- States: IDLE → SETUP → STROBE → HOLD → DONE → IDLE. A single phase counter is loaded on each state entry.
- IDLE
  - Accepting `rd_req`: latch `rd_rs`, go to SETUP.
  - Otherwise, if `poll_en` and the poll counter reaches 0: start a read with RS=0.
- SETUP: `lcd_rw`=1, `lcd_rs` = latched RS, `lcd_en`=0.
- STROBE: `lcd_en`=1. On the final cycle, register `lcd_data_in` into a capture register.
- HOLD: `lcd_en`=0, RW and RS held.
- DONE: `bus_active`=0 and `rd_valid`=1. Load `rd_data`.
  - If RS was 0, also update `busy_flag`, `addr_counter`, and `lcd_busy` (`lcd_busy` = bit 7).
- Outside SETUP/STROBE/HOLD: `lcd_rw`=`lcd_en`=`lcd_rs`=0.
- Poll counter:
  - Reloads to `POLL_CYCLES-1` on entry to IDLE.
  - Decrements only while IDLE, `poll_en`=1 and `bus_gnt`=1.
  - Saturates at 0 until a read can start.
- `lcd_busy` is forced to 1 from reset until the first RS=0 read completes. RS=1 reads never change it.

## Timing
- Reset values: state IDLE, all LCD lines 0, `bus_active`=0, `rd_ready`=0 during reset, `rd_valid`=0, `rd_data`=0, `busy_flag`=1, `addr_counter`=0, `lcd_busy`=1, poll counter `POLL_CYCLES-1`.
- Latency: accept at edge N → SETUP N+1..N+3 → STROBE N+4..N+15 (sample at N+15) → HOLD N+16..N+17 → `rd_valid` at N+18. That is `SETUP+EN_HIGH+HOLD+1` clocks.
- `rd_ready` is low from the accept edge until the cycle after DONE. Requests made while not ready are ignored, not queued.
- If `rd_req` and poll expiry occur in the same cycle, the explicit request wins and the poll counter reloads.
- If `bus_gnt` drops mid-read, the read still completes. The write bridge must not drive the bus while `bus_active` is high.
- Reset mid-read: EN/RW return to 0 on the next edge and no `rd_valid` is issued.
- Back-to-back reads have at least one IDLE cycle between DONE and the next SETUP.

## Structure
- Shared package `lcd_pkg` holds:
  - the state enum;
  - default timing constants;
  - `BF_BIT`=7;
  - RS encodings (`RS_INSTR`=0, `RS_DATA`=1).
- One sub-module, `lcd_phase_counter`: a loadable down-counter with a terminal-count flag. It is reused for phase timing and for the poll interval.

## Test plan
1. Reset, then `poll_en`=1, `bus_gnt`=1, LCD model returns 0x85. After 50 idle clocks a read runs: EN high exactly 12 clocks, `rd_valid` pulses, `busy_flag`=1, `addr_counter`=0x05, `lcd_busy`=1.
2. LCD model returns 0x27 on the next poll → `lcd_busy`=0, `addr_counter`=0x27.
3. `rd_req` with `rd_rs`=1 while the model returns 0x41 → `lcd_rs`=1 throughout, `rd_data`=0x41 at N+18, `lcd_busy` unchanged.
4. `rd_req` in the same cycle as poll expiry → exactly one read with RS=`rd_rs`, then the next poll occurs 50 clocks after returning to IDLE.
5. `bus_gnt`=0 → no read starts, `rd_ready`=0, counter holds at 0. Raising `bus_gnt` starts the read on the next edge.
6. Assert `reset` during STROBE → `lcd_en`=0 on the next edge, no `rd_valid`, `lcd_busy`=1.
